sdram_port_arbiter: RTL

- Shares the single byte-wide SDRAM port between three requesters: the ROM/cartridge downloader (LDR), the RAM eraser (ERA) and the CPU (CPU).
- Fixed-priority grant with a single outstanding access; the grant is held until the SDRAM controller reports completion.
- A watchdog aborts hung accesses and raises a sticky error.
- Sits between the requester modules and the SDRAM controller in the top level.

---
 rtl/sdram_port_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the byte-wide SDRAM port between the downloader
// (LDR), the RAM eraser (ERA) and the CPU. Fixed priority LDR > ERA > CPU,
// one outstanding access, grant held until mem_done or a watchdog abort.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | no access in flight; arbitrate when ena=1 and no ack pending
//   S_BUSY | access owned by grant_q; mem_* frozen, watchdog running
module sdram_port_arbiter #(
  parameter int AW      = 25,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ena,
  input  logic          ldr_req,
  input  logic          era_req,
  input  logic          cpu_req,
  input  logic          ldr_wr,
  input  logic          era_wr,
  input  logic          cpu_wr,
  input  logic [AW-1:0] ldr_addr,
  input  logic [AW-1:0] era_addr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    ldr_din,
  input  logic [7:0]    era_din,
  input  logic [7:0]    cpu_din,
  output logic          ldr_ack,
  output logic          era_ack,
  output logic          cpu_ack,
  output logic [7:0]    rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  input  logic          mem_done,
  output logic [1:0]    grant,
  output logic          timeout_err,
  input  logic          err_clr
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Watchdog value seen during the last BUSY cycle allowed before abort.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_wr_q, mem_wr_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_din_q, mem_din_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [2:0]      ack_q, ack_d;      // {cpu, era, ldr}
  logic            err_q, err_d;
  logic [7:0]      wdog_q, wdog_d;

  // State and datapath registers; reset aborts any access without an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'd0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 8'd0;
      rdata_q    <= 8'd0;
      ack_q      <= 3'b000;
      err_q      <= 1'b0;
      wdog_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mem_req_q  <= mem_req_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  // Arbitration, completion/abort handling and the sticky error flag.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mem_req_d  = mem_req_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    ack_d      = 3'b000;
    err_d      = err_q;
    wdog_d     = wdog_q;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // While an ack is out the owner's req is still high; wait one cycle
        // so the same requester is not granted twice for one transfer.
        if (ena && (ack_q == 3'b000)) begin
          if (ldr_req) begin
            grant_d    = 2'd1;
            mem_wr_d   = ldr_wr;
            mem_addr_d = ldr_addr;
            mem_din_d  = ldr_din;
          end else if (era_req) begin
            grant_d    = 2'd2;
            mem_wr_d   = era_wr;
            mem_addr_d = era_addr;
            mem_din_d  = era_din;
          end else if (cpu_req) begin
            grant_d    = 2'd3;
            mem_wr_d   = cpu_wr;
            mem_addr_d = cpu_addr;
            mem_din_d  = cpu_din;
          end
          if (ldr_req || era_req || cpu_req) begin
            mem_req_d = 1'b1;
            wdog_d    = 8'd0;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        wdog_d = wdog_q + 8'd1;
        // mem_done on the abort edge is treated as a normal completion.
        if (mem_done || (wdog_q == WD_LAST)) begin
          mem_req_d = 1'b0;
          grant_d   = 2'd0;
          state_d   = S_IDLE;
          case (grant_q)
            2'd1:    ack_d = 3'b001;
            2'd2:    ack_d = 3'b010;
            2'd3:    ack_d = 3'b100;
            default: ack_d = 3'b000;
          endcase
          if (mem_done) begin
            rdata_d = mem_dout;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ldr_ack     = ack_q[0];
  assign era_ack     = ack_q[1];
  assign cpu_ack     = ack_q[2];
  assign rdata       = rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign grant       = grant_q;
  assign timeout_err = err_q;

endmodule
